thor2023_ifetch_align: RTL and testbench
========================================

// Module: thor2023_ifetch_align
// PURPOSE
//  Byte-stream instruction align buffer ahead of immediate/instruction decode.
//  - Accepts fixed-width fetch beats from the I-cache.
//  - Presents a 25-byte window as five 40-bit parcels ir..ir5 plus the PC of ir.
//  - Advances by the decode-supplied inc (5/10/15/20 bytes) on each handshake.
//  - Handles PC redirects, including a mid-beat start offset.
// PARAMETERS
//  FETCH_BYTES  16  bytes per fetch beat; power of 2, >= 8
//  BUF_BYTES    48  buffer capacity in bytes; must be >= WIN_BYTES+FETCH_BYTES
//  WIN_BYTES    25  output window size in bytes (5 parcels x 5 bytes); fixed
// PORTS
//  clk          in   1               core clock
//  rst          in   1               synchronous, active-high reset
//  redirect     in   1               flush buffer, restart at redirect_pc
//  redirect_pc  in   32              new fetch PC, byte address
//  fetch_valid  in   1               fetch beat valid
//  fetch_ready  out  1               buffer can accept a beat
//  fetch_data   in   FETCH_BYTES*8   beat; byte 0 in bits [7:0] is the lowest address
//  out_valid    out  1               window holds >= WIN_BYTES valid bytes
//  out_ready    in   1               decode consumes window this cycle
//  inc          in   5               bytes to consume (decode's PC increment)
//  ir..ir5      out  40 each         instruction_t parcels: buffer bytes 0-4 .. 20-24
//  out_pc       out  32              byte address of ir
//  stall_cnt    out  32              present only with THOR2023_ALIGN_STATS_EN
// BEHAVIOUR
//  Reset
//  - State IDLE; count=0; out_pc=0; out_valid=0; fetch_ready=0; stall_cnt=0.
//  - Buffer contents are don't-care.
//  States
//  - IDLE: fetch_ready=0. Moves to ALIGN on redirect.
//  - ALIGN: awaits the first beat after a redirect. On accept:
//    - drops the low redirect_pc[log2 FETCH_BYTES-1:0] bytes;
//    - loads the remaining bytes at buffer byte 0;
//    - moves to RUN.
//  - RUN: on each accepted beat, appends the whole beat at byte index count.
//  Flow control
//  - fetch_ready = (state!=IDLE) && (count <= BUF_BYTES-FETCH_BYTES).
//  - fetch_ready is registered-state only; there is no combinational path from out_ready or inc.
//  - out_valid = (state==RUN) && (count >= WIN_BYTES). Purely a function of registered state.
//  Consume
//  - Takes effect when out_valid && out_ready.
//  - Shifts the buffer down by inc bytes; out_pc += inc (32-bit wrap).
//  - inc values other than 5/10/15/20 are treated as 5.
//  Simultaneous accept and consume
//  - count' = count - inc + bytes_in.
//  - The new beat lands at index count-inc.
//  Redirect
//  - Highest priority in every state, including mid-consume or mid-accept.
//  - A beat or consume in the same cycle is discarded.
//  - Sets count=0 and out_pc=redirect_pc; next state ALIGN; out_valid is 0 the following cycle.
//  - Upstream guarantees every beat accepted after a redirect belongs to the new path.
//  Other rules
//  - Bytes beyond count in the window are stale; out_valid guards them.
//  - Reset has priority over redirect.
// CONFIGURATION
//  THOR2023_ALIGN_STATS_EN
//  - Defined: stall_cnt counts cycles where state==RUN, out_ready=1 and out_valid=0.
//    It saturates at 2^32-1 and clears only on rst.
//  - Undefined: the stall_cnt port and its counter are absent.
// STRUCTURE
//  Thor2023Pkg
//  - instruction_t (40-bit parcel) and address_t, already present.
//  - Add typedef enum align_state_t {IDLE, ALIGN, RUN}.
//  - Add localparam PARCEL_BYTES=5.
//  Sub-module thor2023_byte_shifter
//  - Combinational barrel shift of the buffer by 0/5/10/15/20 bytes.
//  - Merge-insert of the beat at a byte offset.
//  - Instantiated once.
// TESTING
//  1. rst high 2 cycles -> out_valid=0, fetch_ready=0, out_pc=0, stall_cnt=0.
//  2. redirect_pc=0x1000, then beats of incrementing bytes 0x00.. ->
//     - out_valid after 2 beats (32>=25);
//     - ir=0x0403020100, ir5=0x1817161514.
//  3. redirect_pc=0x100B, beat bytes 0x00-0x0F ->
//     - the first 11 bytes are dropped;
//     - after two more beats, ir bytes = 0x0B..0x0F, out_pc=0x100B.
//  4. RUN with count=32; consume inc=20 with a beat accepted in the same cycle ->
//     - count=28;
//     - ir = old bytes 20-24, out_pc += 20.
//  5. Hold out_ready=0 with fetch_valid=1 ->
//     - fetch_ready drops once count>32;
//     - count never exceeds 48;
//     - no byte is lost or duplicated.
//  6. Redirect in the same cycle as a consume and a beat accept ->
//     - both are discarded;
//     - next cycle count=0, out_pc=redirect_pc, out_valid=0;
//     - stats build: stall_cnt increments while out_ready=1.

Source files
------------

// File: rtl/thor2023_ifetch_align_pkg.sv
// Shared types for the Thor2023 fetch align path: parcel/address types, align FSM states
// and the decode increment-to-parcel mapping.
package thor2023_ifetch_align_pkg;

  typedef logic [39:0] instruction_t;
  typedef logic [31:0] address_t;

  typedef enum logic [1:0] {StIdle, StAlign, StRun} align_state_t;

  localparam int unsigned PARCEL_BYTES = 5;

  // Decode increments other than 10/15/20 bytes fall back to a single parcel.
  function automatic logic [2:0] inc_parcels(input logic [4:0] inc);
    case (inc)
      5'd10:   return 3'd2;
      5'd15:   return 3'd3;
      5'd20:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/thor2023_byte_shifter.sv
// Combinational align-buffer update: shift down by whole parcels, then merge a fetch beat
// in at a byte offset.
module thor2023_byte_shifter
  import thor2023_ifetch_align_pkg::*;
#(
  parameter int unsigned BUF_BYTES   = 48,
  parameter int unsigned FETCH_BYTES = 16,
  parameter int unsigned PW          = 6
) (
  input  logic [BUF_BYTES*8-1:0]   buf_in,
  input  logic [2:0]               shamt,
  input  logic                     ins_en,
  input  logic [PW-1:0]            ins_pos,
  input  logic [FETCH_BYTES*8-1:0] beat,
  output logic [BUF_BYTES*8-1:0]   buf_out
);

  localparam int unsigned BW = BUF_BYTES * 8;

  logic [BW-1:0] shifted;
  logic [BW-1:0] beat_wide;
  logic [BW-1:0] mask;

  always_comb begin
    shifted = buf_in;
    case (shamt)
      3'd1:    shifted = buf_in >> (1 * PARCEL_BYTES * 8);
      3'd2:    shifted = buf_in >> (2 * PARCEL_BYTES * 8);
      3'd3:    shifted = buf_in >> (3 * PARCEL_BYTES * 8);
      3'd4:    shifted = buf_in >> (4 * PARCEL_BYTES * 8);
      default: shifted = buf_in;
    endcase
  end

  always_comb begin
    beat_wide = BW'(beat) << {ins_pos, 3'b000};
    mask      = BW'({(FETCH_BYTES * 8){1'b1}}) << {ins_pos, 3'b000};
    buf_out   = ins_en ? ((shifted & ~mask) | beat_wide) : shifted;
  end

endmodule

// File: rtl/thor2023_ifetch_align.sv
// Byte-stream instruction align buffer: fetch beats in, 25-byte parcel window out.
// Optional stall counter enabled by defining THOR2023_ALIGN_STATS_EN.
module thor2023_ifetch_align
  import thor2023_ifetch_align_pkg::*;
#(
  parameter int unsigned FETCH_BYTES = 16,
  parameter int unsigned BUF_BYTES   = 48,
  parameter int unsigned WIN_BYTES   = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  address_t                 redirect_pc,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [FETCH_BYTES*8-1:0] fetch_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic [4:0]               inc,
  output instruction_t             ir,
  output instruction_t             ir2,
  output instruction_t             ir3,
  output instruction_t             ir4,
  output instruction_t             ir5,
  output address_t                 out_pc
`ifdef THOR2023_ALIGN_STATS_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(BUF_BYTES + 1);
  localparam int unsigned OW = $clog2(FETCH_BYTES);

  align_state_t            state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [BUF_BYTES*8-1:0]  buf_q, buf_d;
  address_t                out_pc_q, out_pc_d;
  logic [OW-1:0]           off_q, off_d;

  logic                    accept, consume;
  logic [2:0]              parcels;
  logic [CW-1:0]           inc_bytes, bytes_in, ins_pos;
  logic [FETCH_BYTES*8-1:0] beat_aligned;

  assign accept    = fetch_valid & fetch_ready;
  assign consume   = out_valid & out_ready;
  assign parcels   = consume ? inc_parcels(inc) : 3'd0;
  assign inc_bytes = CW'(parcels) * CW'(PARCEL_BYTES);
  // With a simultaneous consume the beat lands just past the surviving bytes.
  assign ins_pos   = count_q - inc_bytes;

  // First beat after a redirect drops the bytes below the redirect target.
  always_comb begin
    beat_aligned = fetch_data;
    bytes_in     = CW'(FETCH_BYTES);
    if (state_q == StAlign) begin
      beat_aligned = fetch_data >> {off_q, 3'b000};
      bytes_in     = CW'(FETCH_BYTES) - CW'(off_q);
    end
  end

  thor2023_byte_shifter #(
    .BUF_BYTES   (BUF_BYTES),
    .FETCH_BYTES (FETCH_BYTES),
    .PW          (CW)
  ) u_shifter (
    .buf_in  (buf_q),
    .shamt   (parcels),
    .ins_en  (accept),
    .ins_pos (ins_pos),
    .beat    (beat_aligned),
    .buf_out (buf_d)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect)                          state_d = StAlign;
    else if (state_q == StAlign && accept) state_d = StRun;
  end

  always_comb begin
    fetch_ready = (state_q != StIdle) && (count_q <= CW'(BUF_BYTES - FETCH_BYTES));
    out_valid   = (state_q == StRun) && (count_q >= CW'(WIN_BYTES));
  end

  always_comb begin
    count_d  = count_q - inc_bytes + (accept ? bytes_in : '0);
    out_pc_d = out_pc_q + 32'(inc_bytes);
    off_d    = off_q;
    if (redirect) begin
      count_d  = '0;
      out_pc_d = redirect_pc;
      off_d    = redirect_pc[OW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      out_pc_q <= '0;
      off_q    <= '0;
    end else begin
      count_q  <= count_d;
      out_pc_q <= out_pc_d;
      off_q    <= off_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

`ifdef THOR2023_ALIGN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state_q == StRun && out_ready && !out_valid && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  assign ir     = buf_q[0*40 +: 40];
  assign ir2    = buf_q[1*40 +: 40];
  assign ir3    = buf_q[2*40 +: 40];
  assign ir4    = buf_q[3*40 +: 40];
  assign ir5    = buf_q[4*40 +: 40];
  assign out_pc = out_pc_q;

endmodule

// File: tb/tb_thor2023_ifetch_align.sv
// Self-checking bench for thor2023_ifetch_align: directed cases plus random traffic
// against a byte-queue reference model.
module tb_thor2023_ifetch_align;

  logic         clk = 1'b0;
  logic         rst;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         fetch_valid;
  logic         fetch_ready;
  logic [127:0] fetch_data;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   inc;
  logic [39:0]  ir, ir2, ir3, ir4, ir5;
  logic [31:0]  out_pc;
`ifdef THOR2023_ALIGN_STATS_EN
  logic [31:0]  stall_cnt;
`endif

  always #5 clk = ~clk;

  thor2023_ifetch_align dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .inc         (inc),
    .ir          (ir),
    .ir2         (ir2),
    .ir3         (ir3),
    .ir4         (ir4),
    .ir5         (ir5),
    .out_pc      (out_pc)
`ifdef THOR2023_ALIGN_STATS_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: valid bytes as a queue, mode 0=idle 1=align 2=run.
  logic [7:0]  mq[$];
  int          m_mode;
  int          m_off;
  logic [31:0] m_pc;
  logic [31:0] m_stall;

  function automatic bit m_fr();
    return m_mode != 0 && mq.size() <= 32;
  endfunction

  function automatic bit m_ov();
    return m_mode == 2 && mq.size() >= 25;
  endfunction

  function automatic logic [39:0] m_parcel(input int k);
    logic [39:0] p;
    for (int b = 0; b < 5; b++) p[b*8 +: 8] = mq[k*5 + b];
    return p;
  endfunction

  function automatic int inc_eff(input logic [4:0] v);
    return (v == 10 || v == 15 || v == 20) ? int'(v) : 5;
  endfunction

  function automatic logic [127:0] beat_inc(input logic [7:0] start);
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = start + 8'(i);
    return d;
  endfunction

  task automatic compare_all();
    check_eq("fetch_ready", {63'd0, fetch_ready}, {63'd0, m_fr()});
    check_eq("out_valid", {63'd0, out_valid}, {63'd0, m_ov()});
    check_eq("out_pc", {32'd0, out_pc}, {32'd0, m_pc});
    if (m_ov()) begin
      check_eq("ir", {24'd0, ir}, {24'd0, m_parcel(0)});
      check_eq("ir2", {24'd0, ir2}, {24'd0, m_parcel(1)});
      check_eq("ir3", {24'd0, ir3}, {24'd0, m_parcel(2)});
      check_eq("ir4", {24'd0, ir4}, {24'd0, m_parcel(3)});
      check_eq("ir5", {24'd0, ir5}, {24'd0, m_parcel(4)});
    end
`ifdef THOR2023_ALIGN_STATS_EN
    check_eq("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_stall});
`endif
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic fv,
                      input logic [127:0] fd, input logic ordy, input logic [4:0] ic);
    bit fr, ov;
    redirect    = rd;
    redirect_pc = rpc;
    fetch_valid = fv;
    fetch_data  = fd;
    out_ready   = ordy;
    inc         = ic;
    fr = m_fr();
    ov = m_ov();
    if (m_mode == 2 && ordy && !ov && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (rd) begin
      mq.delete();
      m_pc   = rpc;
      m_mode = 1;
      m_off  = int'(rpc[3:0]);
    end else begin
      if (ov && ordy) begin
        for (int i = 0; i < inc_eff(ic); i++) void'(mq.pop_front());
        m_pc += 32'(inc_eff(ic));
      end
      if (fr && fv) begin
        for (int i = (m_mode == 1 ? m_off : 0); i < 16; i++) mq.push_back(fd[i*8 +: 8]);
        m_mode = 2;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; fetch_valid = 1'b0;
    fetch_data = '0; out_ready = 1'b0; inc = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); m_mode = 0; m_off = 0; m_pc = '0; m_stall = '0;
    compare_all();
    rst = 1'b0;

    // Idle ignores beats.
    step(1'b0, 32'h0, 1'b1, beat_inc(8'h80), 1'b1, 5'd5);

    // Aligned redirect, two beats fill the window.
    step(1'b1, 32'h1000, 1'b0, '0, 1'b0, 5'd5);
    step(1'b0, 32'h0, 1'b1, beat_inc(8'h00), 1'b0, 5'd5);
    check_eq("t2_not_valid_1beat", {63'd0, out_valid}, 64'd0);
    step(1'b0, 32'h0, 1'b1, beat_inc(8'h10), 1'b0, 5'd5);
    check_eq("t2_valid", {63'd0, out_valid}, 64'd1);
    check_eq("t2_ir", {24'd0, ir}, 64'h04_0302_0100);
    check_eq("t2_ir5", {24'd0, ir5}, 64'h18_1716_1514);

    // Consume 20 with a beat in the same cycle.
    step(1'b0, 32'h0, 1'b1, beat_inc(8'h20), 1'b1, 5'd20);
    check_eq("t4_ir", {24'd0, ir}, 64'h18_1716_1514);
    check_eq("t4_pc", {32'd0, out_pc}, 64'h1014);
    check_eq("t4_count", 64'(mq.size()), 64'd28);

    // Back-pressure: buffer fills and stops accepting.
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, beat_inc(8'h30 + 8'(i*16)), 1'b0, 5'd5);
    check_eq("t5_ready_low", {63'd0, fetch_ready}, 64'd0);
    check_eq("t5_count", 64'(mq.size()), 64'd44);
    step(1'b0, 32'h0, 1'b0, '0, 1'b1, 5'd15);

    // Redirect wins over simultaneous consume and accept.
    step(1'b1, 32'h2000, 1'b1, beat_inc(8'h70), 1'b1, 5'd5);
    check_eq("t6_valid", {63'd0, out_valid}, 64'd0);
    check_eq("t6_pc", {32'd0, out_pc}, 64'h2000);

    // Mid-beat redirect target.
    step(1'b1, 32'h100B, 1'b0, '0, 1'b0, 5'd5);
    step(1'b0, 32'h0, 1'b1, beat_inc(8'h00), 1'b0, 5'd5);
    step(1'b0, 32'h0, 1'b1, beat_inc(8'h10), 1'b0, 5'd5);
    step(1'b0, 32'h0, 1'b1, beat_inc(8'h20), 1'b0, 5'd5);
    check_eq("t3_ir", {24'd0, ir}, 64'h0F_0E0D_0C0B);
    check_eq("t3_ir2", {24'd0, ir2}, 64'h14_1312_1110);
    check_eq("t3_pc", {32'd0, out_pc}, 64'h100B);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [127:0] d;
      for (int w = 0; w < 4; w++) d[w*32 +: 32] = $urandom;
      step(($urandom_range(39) == 0), $urandom, ($urandom_range(9) < 7), d,
           ($urandom_range(9) < 6), 5'($urandom_range(31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
